// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake and memory-side bus shared by the data-memory arbiter.
// slave = arbiter view; master = requesters plus the memory instance.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 16
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_adr;
  logic [DW-1:0] mem_dat_in;
  logic [AW-1:0] mem_rd_adr;
  logic [DW-1:0] mem_dat_out;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dat_out,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
    output mem_wr_en, mem_wr_adr, mem_dat_in, mem_rd_adr
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dat_out,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
    input  mem_wr_en, mem_wr_adr, mem_dat_in, mem_rd_adr
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of one synchronous-read data memory,
// with read-return routing and per-port saturating stall counters.
module dmem_arbiter #(
  parameter int unsigned AW     = 10,
  parameter int unsigned DW     = 16,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  dmem_arbiter_if.slave    bus,
  output logic [2:0]       rd_pending,
  output logic [CNT_W-1:0] stall0,
  output logic [CNT_W-1:0] stall1
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  port_e           last_q;
  port_e           last_d;
  logic            gnt0;
  logic            gnt1;
  logic            rd_gnt;
  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] pid_q;
  logic [RD_LAT:0]   vld_sh;
  logic [RD_LAT:0]   pid_sh;
  logic            ret_vld;
  logic            ret_pid;

  // State register: last_grant
  always_ff @(posedge clk) begin
    if (reset) last_q <= PORT1;
    else       last_q <= last_d;
  end

  // Next state: only cycles carrying a grant move last_grant
  always_comb begin
    last_d = last_q;
    if (gnt0)      last_d = PORT0;
    else if (gnt1) last_d = PORT1;
  end

  // Outputs: grant decision and memory port drive
  always_comb begin
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    bus.mem_wr_en  = 1'b0;
    bus.mem_wr_adr = '0;
    bus.mem_rd_adr = '0;
    bus.mem_dat_in = '0;
    if (!reset) begin
      if (bus.req0 && bus.req1) begin
        gnt0 = (last_q == PORT1);
        gnt1 = (last_q == PORT0);
      end else begin
        gnt0 = bus.req0;
        gnt1 = bus.req1;
      end
    end
    if (gnt0) begin
      bus.mem_wr_en  = bus.we0;
      bus.mem_wr_adr = bus.addr0;
      bus.mem_rd_adr = bus.addr0;
      bus.mem_dat_in = bus.wdata0;
    end else if (gnt1) begin
      bus.mem_wr_en  = bus.we1;
      bus.mem_wr_adr = bus.addr1;
      bus.mem_rd_adr = bus.addr1;
      bus.mem_dat_in = bus.wdata1;
    end
  end

  assign bus.gnt0 = gnt0;
  assign bus.gnt1 = gnt1;
  assign rd_gnt   = (gnt0 && !bus.we0) || (gnt1 && !bus.we1);

  // The shifted-in vectors double as the shift source and the return tap,
  // so RD_LAT = 1 needs no special case.
  assign vld_sh  = {vld_q, rd_gnt};
  assign pid_sh  = {pid_q, gnt1};
  assign ret_vld = vld_sh[RD_LAT];
  assign ret_pid = pid_sh[RD_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      pid_q <= '0;
    end else begin
      vld_q <= vld_sh[RD_LAT-1:0];
      pid_q <= pid_sh[RD_LAT-1:0];
    end
  end

  assign bus.rvalid0 = ret_vld && !ret_pid;
  assign bus.rvalid1 = ret_vld && ret_pid;
  assign bus.rdata   = bus.mem_dat_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pending <= '0;
    end else begin
      case ({rd_gnt, ret_vld})
        2'b10:   rd_pending <= rd_pending + 3'd1;
        2'b01:   rd_pending <= rd_pending - 3'd1;
        default: rd_pending <= rd_pending;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall0 <= '0;
      stall1 <= '0;
    end else begin
      if (bus.req0 && !gnt0 && (stall0 != '1)) stall0 <= stall0 + CNT_W'(1);
      if (bus.req1 && !gnt1 && (stall1 != '1)) stall1 <= stall1 + CNT_W'(1);
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter that shares one data-memory instance (16-bit data, 10-bit address, synchronous read, separate read/write address ports) between two requesters, e.g. core load/store (port 0) and debug/loader (port 1).
- Grants at most one access per cycle, drives the memory's write and read ports, and routes returning read data to the owner with a matching valid pulse.
- Keeps per-port saturating stall counters for performance debug.

Parameters:
- AW, 10, address width (memory depth 2^AW words).
- DW, 16, data width.
- RD_LAT, 1, memory read latency in cycles (address sampled at edge, data valid RD_LAT cycles later); legal 1..4.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request; held with we/addr/wdata stable until granted.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  AW  word address.
- wdata0 / wdata1  in  DW  write data.
- gnt0 / gnt1  out  1  combinational grant; access completes at the edge where req&gnt.
- rvalid0 / rvalid1  out  1  read data valid for that port (registered).
- rdata  out  DW  shared read-return bus (= mem_dat_out); meaningful only with an rvalid.
- mem_wr_en  out  1  memory write enable.
- mem_wr_adr  out  AW  memory write address.
- mem_dat_in  out  DW  memory write data.
- mem_rd_adr  out  AW  memory read address.
- mem_dat_out  in  DW  memory read data.
- rd_pending  out  3  number of granted reads whose data has not returned.
- stall0 / stall1  out  CNT_W  saturating count of cycles with req high and gnt low.

Behaviour:
- Reset (sync): last_grant = 1 (so port 0 wins the first tie), read-return pipeline cleared, rvalid0/1 = 0, rd_pending = 0, stall0/1 = 0. While reset is high, gnt0/1 = 0 and mem_wr_en = 0.
- Arbitration (combinational):
  - Only req0 high: gnt0. Only req1 high: gnt1.
  - Both high: grant the port not equal to last_grant.
  - last_grant updates only on cycles with a grant. Neither requesting: no grant, last_grant holds.
- Memory drive:
  - mem_wr_en = granted & we of the granted port.
  - mem_wr_adr = mem_rd_adr = granted addr; mem_dat_in = granted wdata.
  - No grant: addresses/data driven 0, mem_wr_en = 0.
- Read return:
  - Pipeline of RD_LAT stages, each holding {valid, port_id}. Stage 0 is loaded at the edge that ends a read-grant cycle N.
  - rvalid_k is high for exactly cycle N+RD_LAT when port_id = k.
  - Writes never produce rvalid.
- Throughput: back-to-back grants every cycle; reads stay in grant order; both rvalids are never high together.
- Ordering: a write granted in cycle N followed by a read of the same address granted in N+1 returns the new data.
- rd_pending: +1 on a read grant, -1 when an rvalid fires, net 0 when both occur in the same cycle. Max value RD_LAT.
- Stall counters: increment on each cycle with req_k & !gnt_k; saturate at 2^CNT_W-1 with no wrap.
- Reset mid-operation: in-flight reads are dropped, no rvalid after reset, counters cleared.
- Requester protocol violations (changing addr/we while waiting) are undefined; the bench treats them as errors.

Test Plan:
- Reset 2 cycles, then idle: gnt0/1 = 0, mem_wr_en = 0, rvalid0/1 = 0, rd_pending = 0, stall0/1 = 0.
- Port 0 writes 0x00AB to addr 3, then reads addr 3 (RD_LAT = 1) -> gnt0 both cycles; mem_wr_en high for one cycle only; rvalid0 high in the cycle after the read grant with rdata = 0x00AB; rvalid1 stays 0.
- req0 and req1 held high continuously, reads to addr 1 and 2 -> grants alternate 0,1,0,1 starting with port 0; rvalid pattern follows one cycle later; stall0/1 each increase by 1 every two cycles.
- Port 1 reads addr 0x3FF, then port 0 writes 0x1234 to 0x3FF the next cycle -> port 1 receives the old value; a subsequent port 1 read returns 0x1234.
- RD_LAT = 3, four consecutive reads alternating ports -> rd_pending rises to 3 and holds 3; each rvalid fires exactly 3 cycles after its grant with the correct port_id.
- Read granted, reset asserted the next cycle (RD_LAT = 2) -> no rvalid ever appears for it; rd_pending = 0 and stall counters = 0 after reset. Separately, hold req1 blocked with CNT_W = 4 for 20 cycles -> stall1 saturates at 15.
